capture_ctrl: RTL and testbench
===============================

# capture_ctrl

Capture sequencer for the 4-channel logic analyzer. It sits in front of the four per-channel `data_path` instances and drives their shared `reset`, `start`, `zoom` and `offset` inputs. It runs the flow idle → clear → armed (wait for trigger) → capture → display, and owns the user zoom/offset settings.

## Interface
Parameters:
- `CLEAR_CYCLES`, default 4: cycles `dp_reset` is held in CLEAR.
- `TIMEOUT_W`, default 24: width of the capture timeout counter.
- `TIMEOUT`, default 24'hFF_FFFF: CAPTURE cycles before forced exit.
- `ZOOM_MAX`, default 4'd9: upper saturation value of `zoom`.

Ports:
- `clk` in 1: single system clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-low (asserted when 0).
- `ch_in` in 4: raw probe inputs, asynchronous; synchronized internally by 2 FF per bit.
- `arm` in 1: synchronous level; its rising edge is detected internally.
- `abort` in 1: synchronous level; when high, return to IDLE.
- `trig_ch` in 2: trigger channel select.
- `trig_mode` in 2: trigger condition. 00 immediate, 01 rising, 10 falling, 11 any edge.
- `zoom_inc`, `zoom_dec`, `off_inc`, `off_dec` in 1 each: single-cycle synchronous pulses.
- `dp_full` in 4: per-channel write-complete flags (address bit 13) from the data paths.
- `dp_reset` out 1: active-high clear to all data paths.
- `dp_start` out 1: capture enable to all data paths.
- `zoom` out 4, `offset` out 3: to all data paths.
- `state` out 3: current FSM state, for status LEDs.
- `timed_out` out 1: last capture ended on timeout.
- `busy` out 1: high in CLEAR, ARMED or CAPTURE.

## Operation
- States: IDLE=0, CLEAR=1, ARMED=2, CAPTURE=3, DISPLAY=4.
- IDLE → CLEAR on `arm` rising edge.
- DISPLAY → CLEAR on `arm` rising edge.
- CLEAR: `dp_reset`=1 for exactly CLEAR_CYCLES cycles, then → ARMED. `timed_out` is cleared on CLEAR entry.
- ARMED: trigger is evaluated on the synchronized sample `s` and the previous sample `p` of channel `trig_ch`.
  - Rising: `!p & s`. Falling: `p & !s`. Any edge: `p ^ s`. Immediate: always true.
  - When the trigger is true → CAPTURE.
  - `p` is reloaded on ARMED entry, so an edge that occurred before arming never triggers.
- CAPTURE: `dp_start`=1.
  - `dp_full`==4'hF → DISPLAY.
  - Otherwise, timeout counter reaching TIMEOUT-1 → DISPLAY with `timed_out`=1.
  - If both happen in the same cycle, full wins and `timed_out`=0.
- DISPLAY: `dp_start`=0, `dp_reset`=0. The data paths serve readout.
- `abort` high in CLEAR, ARMED or CAPTURE → IDLE next cycle, `dp_start`=0. Abort outranks every other transition. Abort in IDLE or DISPLAY is ignored.
- `arm` edges in CLEAR, ARMED or CAPTURE are ignored and are not queued.
- Zoom and offset are accepted in every state.
  - Saturating up/down: `zoom` stays within 0..ZOOM_MAX, `offset` within 0..7.
  - inc and dec high in the same cycle: no change.
  - Values persist across captures and are reset only by `reset`.
- `dp_full` is ignored outside CAPTURE.

## Timing
- Reset values:
  - `state`=IDLE.
  - `dp_reset`=0, `dp_start`=0, `zoom`=0, `offset`=0, `timed_out`=0, `busy`=0.
  - Sync/edge registers and counters are 0.
- All outputs are registered, with no combinational path from input to output.
- `ch_in` to trigger decision: 2 sync cycles plus 1 compare cycle. `dp_start` rises the cycle after the trigger-true cycle.
- Immediate mode: ARMED lasts exactly 1 cycle.
- `arm` rising edge at cycle N: `state`=CLEAR and `dp_reset`=1 at N+1, through N+CLEAR_CYCLES. ARMED at N+CLEAR_CYCLES+1.
- Zoom/offset pulse at cycle N: new value visible at N+1.
- The timeout counter clears on CAPTURE entry and counts every CAPTURE cycle. Width arithmetic is modulo 2^TIMEOUT_W and never wraps in use.
- Async `reset` mid-capture: immediate IDLE and `dp_start`=0. Data path contents are undefined afterwards; the next `arm` clears them.

## Structure
- Shared include `la_defs.vh` holds:
  - State encodings.
  - `trig_mode` codes.
  - Data path address width (14) and display bit index (13).
- Sub-module `sat_counter` (parameters WIDTH, MAX; inputs inc, dec; count output; async active-low reset), instantiated for `zoom` and `offset`.
- Remaining logic: 2-FF synchronizer, arm edge detector, FSM, CLEAR counter, timeout counter, all in `capture_ctrl`.

## Test plan
- Reset, then `arm` pulse with CLEAR_CYCLES=4: `dp_reset` high exactly 4 cycles, then ARMED, `busy`=1.
- `trig_mode`=01, `trig_ch`=2, drive `ch_in[2]` 0→1: `dp_start`=1 exactly 4 cycles after the input change (2 sync + 1 compare + 1 register). A 0→1 on `ch_in[1]` causes no trigger.
- In CAPTURE, raise `dp_full`=4'hF: DISPLAY next cycle, `dp_start`=0, `timed_out`=0. Then `dp_full`=4'h7 with TIMEOUT=16: DISPLAY after 16 CAPTURE cycles, `timed_out`=1.
- Twelve `zoom_inc` pulses: `zoom` saturates at 9. Eight `off_dec` from 0: `offset` stays 0. Simultaneous `zoom_inc` and `zoom_dec`: no change.
- `abort` in CAPTURE together with `dp_full`=4'hF: IDLE, not DISPLAY. `arm` during ARMED: ignored, state unchanged.
- Async `reset` low mid-CAPTURE: all outputs return to their reset values without waiting for a clock edge.

Source files
------------

// File: rtl/capture_ctrl_pkg.sv
// Shared definitions for the logic-analyzer capture sequencer.
// Holds the FSM state encodings, trigger-mode codes, data path address geometry and the
// trigger-condition helper used by capture_ctrl.
package capture_ctrl_pkg;

  // FSM state encodings, also exported on the status LEDs.
  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StClear   = 3'd1;
  localparam logic [2:0] StArmed   = 3'd2;
  localparam logic [2:0] StCapture = 3'd3;
  localparam logic [2:0] StDisplay = 3'd4;

  // Trigger condition codes on trig_mode.
  typedef enum logic [1:0] {
    TrigImm  = 2'b00,
    TrigRise = 2'b01,
    TrigFall = 2'b10,
    TrigAny  = 2'b11
  } trig_mode_e;

  // Data path sample memory geometry; address bit DpDispBit flags a full buffer.
  localparam int unsigned DpAddrW   = 14;
  localparam int unsigned DpDispBit = 13;

  // Trigger condition on the previous (prev) and current (cur) synchronized sample.
  function automatic logic trig_hit(logic [1:0] mode, logic prev, logic cur);
    logic hit;
    case (mode)
      TrigRise: hit = ~prev & cur;
      TrigFall: hit = prev & ~cur;
      TrigAny:  hit = prev ^ cur;
      default:  hit = 1'b1;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/capture_ctrl_if.sv
// Bundle of user-control, probe and data path signals around capture_ctrl.
// master: the capture sequencer (consumes probes/controls, drives data path controls).
// slave:  the surrounding system (user controls, probes, the four data paths).
interface capture_ctrl_if;
  // Inputs to the sequencer.
  logic [3:0] ch_in;
  logic       arm;
  logic       abort;
  logic [1:0] trig_ch;
  logic [1:0] trig_mode;
  logic       zoom_inc;
  logic       zoom_dec;
  logic       off_inc;
  logic       off_dec;
  logic [3:0] dp_full;
  // Outputs from the sequencer.
  logic       dp_reset;
  logic       dp_start;
  logic [3:0] zoom;
  logic [2:0] offset;
  logic [2:0] state;
  logic       timed_out;
  logic       busy;

  modport master (
    input  ch_in, arm, abort, trig_ch, trig_mode, zoom_inc, zoom_dec, off_inc, off_dec,
           dp_full,
    output dp_reset, dp_start, zoom, offset, state, timed_out, busy
  );

  modport slave (
    output ch_in, arm, abort, trig_ch, trig_mode, zoom_inc, zoom_dec, off_inc, off_dec,
           dp_full,
    input  dp_reset, dp_start, zoom, offset, state, timed_out, busy
  );
endinterface

// File: rtl/capture_ctrl_sat_counter.sv
// Saturating up/down counter used for the zoom and offset settings.
// Ports: clk_i, rst_ni (async active-low), inc_i/dec_i (single-cycle pulses),
//        count_o (current value, held within 0..MAX).
// inc_i and dec_i together leave the count unchanged.
module capture_ctrl_sat_counter #(
  parameter int unsigned      WIDTH = 4,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             dec_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i && (count_q < MAX)) begin
      count_d = count_q + 1'b1;
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer for the 4-channel logic analyzer.
// Runs idle -> clear -> armed -> capture -> display and drives the shared reset/start/zoom/
// offset controls of the four data paths.
// Ports: clk (rising edge), reset (async, active-low), bus (capture_ctrl_if.master):
//   inputs  ch_in (async probes), arm, abort, trig_ch, trig_mode, zoom/off inc/dec, dp_full
//   outputs dp_reset, dp_start, zoom, offset, state, timed_out, busy (all from registers)
module capture_ctrl
  import capture_ctrl_pkg::*;
#(
  parameter int unsigned          CLEAR_CYCLES = 4,
  parameter int unsigned          TIMEOUT_W    = 24,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT      = 24'hFF_FFFF,
  parameter logic [3:0]           ZOOM_MAX     = 4'd9
) (
  input logic            clk,
  input logic            reset,
  capture_ctrl_if.master bus
);

  localparam int unsigned ClrW = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [ClrW-1:0]      ClrLast = ClrW'(CLEAR_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TmoLast = TIMEOUT - 1'b1;

  logic [3:0]           ch_s1_q, ch_s2_q;
  logic                 prev_q;
  logic                 trig_d, trig_q;
  logic                 arm_q;
  logic                 arm_rise;
  logic                 sel_s;
  logic [2:0]           state_d, state_q;
  logic [ClrW-1:0]      clr_cnt_d, clr_cnt_q;
  logic [TIMEOUT_W-1:0] tmo_cnt_d, tmo_cnt_q;
  logic                 timed_out_d, timed_out_q;

  assign sel_s    = ch_s2_q[bus.trig_ch];
  assign arm_rise = bus.arm & ~arm_q;

  // Trigger compare is registered; it is only armed while in ARMED so that an edge seen
  // during CLEAR cannot leak into the first ARMED cycle.
  assign trig_d = (state_q == StArmed) && trig_hit(bus.trig_mode, prev_q, sel_s);

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    timed_out_d = timed_out_q;
    case (state_q)
      StIdle, StDisplay: begin
        if (arm_rise) begin
          state_d     = StClear;
          clr_cnt_d   = '0;
          timed_out_d = 1'b0;
        end
      end
      StClear: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if (clr_cnt_q == ClrLast) begin
          state_d = StArmed;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      StArmed: begin
        if (bus.abort) begin
          state_d = StIdle;
        end else if ((bus.trig_mode == TrigImm) || trig_q) begin
          state_d   = StCapture;
          tmo_cnt_d = '0;
        end
      end
      StCapture: begin
        // Priority: abort, then all channels full, then timeout.
        if (bus.abort) begin
          state_d = StIdle;
        end else if (&bus.dp_full) begin
          state_d = StDisplay;
        end else if (tmo_cnt_q == TmoLast) begin
          state_d     = StDisplay;
          timed_out_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ch_s1_q     <= '0;
      ch_s2_q     <= '0;
      prev_q      <= 1'b0;
      trig_q      <= 1'b0;
      arm_q       <= 1'b0;
      state_q     <= StIdle;
      clr_cnt_q   <= '0;
      tmo_cnt_q   <= '0;
      timed_out_q <= 1'b0;
    end else begin
      ch_s1_q     <= bus.ch_in;
      ch_s2_q     <= ch_s1_q;
      prev_q      <= sel_s;
      trig_q      <= trig_d;
      arm_q       <= bus.arm;
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  // Outputs decode the state register only, so nothing passes combinationally from inputs.
  assign bus.state     = state_q;
  assign bus.dp_reset  = (state_q == StClear);
  assign bus.dp_start  = (state_q == StCapture);
  assign bus.busy      = (state_q == StClear) || (state_q == StArmed) || (state_q == StCapture);
  assign bus.timed_out = timed_out_q;

  capture_ctrl_sat_counter #(
    .WIDTH(4),
    .MAX  (ZOOM_MAX)
  ) u_zoom (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (bus.zoom_inc),
    .dec_i  (bus.zoom_dec),
    .count_o(bus.zoom)
  );

  capture_ctrl_sat_counter #(
    .WIDTH(3),
    .MAX  (3'd7)
  ) u_offset (
    .clk_i  (clk),
    .rst_ni (reset),
    .inc_i  (bus.off_inc),
    .dec_i  (bus.off_dec),
    .count_o(bus.offset)
  );

endmodule

// File: tb/tb_capture_ctrl.sv
// Scoreboard bench for capture_ctrl: stimulus pushes cycle-stamped expectations, a negedge
// monitor pops and compares them against the DUT outputs.
module tb_capture_ctrl;

  localparam int SelState    = 0;
  localparam int SelDpReset  = 1;
  localparam int SelDpStart  = 2;
  localparam int SelBusy     = 3;
  localparam int SelTimedOut = 4;
  localparam int SelZoom     = 5;
  localparam int SelOffset   = 6;

  typedef struct {
    int    cyc;
    string name;
    int    sel;
    int    val;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb_q[$];

  capture_ctrl_if bus ();

  capture_ctrl #(
    .CLEAR_CYCLES(4),
    .TIMEOUT_W   (24),
    .TIMEOUT     (24'd16),
    .ZOOM_MAX    (4'd9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(int sel);
    case (sel)
      SelState:    return int'(bus.state);
      SelDpReset:  return int'(bus.dp_reset);
      SelDpStart:  return int'(bus.dp_start);
      SelBusy:     return int'(bus.busy);
      SelTimedOut: return int'(bus.timed_out);
      SelZoom:     return int'(bus.zoom);
      default:     return int'(bus.offset);
    endcase
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_at(int off, string name, int sel, int val);
    sb_q.push_back('{cyc + off, name, sel, val});
  endtask

  // Monitor: compare every expectation due this cycle; a stale one counts as missed.
  always @(negedge clk) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc == cyc) begin
        check(sb_q[i].name, sample(sb_q[i].sel), sb_q[i].val);
        sb_q.delete(i);
      end else if (sb_q[i].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL %s: missed, due cycle %0d now %0d", sb_q[i].name, sb_q[i].cyc, cyc);
        sb_q.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b0;
    bus.ch_in     = '0;
    bus.arm       = 1'b0;
    bus.abort     = 1'b0;
    bus.trig_ch   = '0;
    bus.trig_mode = '0;
    bus.zoom_inc  = 1'b0;
    bus.zoom_dec  = 1'b0;
    bus.off_inc   = 1'b0;
    bus.off_dec   = 1'b0;
    bus.dp_full   = '0;

    // Reset values before any clock edge.
    #2;
    check("rst_async_state", int'(bus.state), 0);
    check("rst_async_start", int'(bus.dp_start), 0);
    tick_n(2);
    reset = 1'b1;
    tick();
    exp_at(0, "rst_state", SelState, 0);
    exp_at(0, "rst_dp_reset", SelDpReset, 0);
    exp_at(0, "rst_dp_start", SelDpStart, 0);
    exp_at(0, "rst_busy", SelBusy, 0);
    exp_at(0, "rst_timed_out", SelTimedOut, 0);
    exp_at(0, "rst_zoom", SelZoom, 0);
    exp_at(0, "rst_offset", SelOffset, 0);

    // Arm: CLEAR for exactly 4 cycles, then ARMED.
    bus.trig_mode = 2'b01;
    bus.trig_ch   = 2'd2;
    bus.arm       = 1'b1;
    exp_at(1, "clr_state", SelState, 1);
    exp_at(1, "clr_dp_reset", SelDpReset, 1);
    exp_at(4, "clr_last_dp_reset", SelDpReset, 1);
    exp_at(4, "clr_last_state", SelState, 1);
    exp_at(5, "armed_state", SelState, 2);
    exp_at(5, "armed_dp_reset", SelDpReset, 0);
    exp_at(5, "armed_busy", SelBusy, 1);
    tick();
    bus.arm = 1'b0;
    tick_n(6);

    // Rise on a non-selected channel and an arm pulse while ARMED: no effect.
    bus.ch_in = 4'b0010;
    exp_at(6, "ch1_no_trig", SelState, 2);
    tick();
    bus.arm = 1'b1;
    exp_at(2, "arm_in_armed", SelState, 2);
    tick();
    bus.arm = 1'b0;
    tick_n(4);

    // Rising edge on channel 2: dp_start exactly 4 cycles later.
    bus.ch_in = 4'b0110;
    exp_at(3, "pre_trig_state", SelState, 2);
    exp_at(3, "pre_trig_start", SelDpStart, 0);
    exp_at(4, "trig_state", SelState, 3);
    exp_at(4, "trig_start", SelDpStart, 1);
    tick_n(4);

    // All channels full: DISPLAY next cycle, no timeout flag.
    bus.dp_full = 4'hF;
    exp_at(1, "full_state", SelState, 4);
    exp_at(1, "full_start", SelDpStart, 0);
    exp_at(1, "full_timed_out", SelTimedOut, 0);
    exp_at(1, "full_busy", SelBusy, 0);
    tick();
    bus.dp_full = 4'h0;
    exp_at(1, "arm_not_queued", SelState, 4);
    tick();

    // Immediate trigger, partial full: timeout after 16 CAPTURE cycles.
    bus.trig_mode = 2'b00;
    bus.dp_full   = 4'h7;
    bus.arm       = 1'b1;
    exp_at(5, "imm_armed", SelState, 2);
    exp_at(6, "imm_capture", SelState, 3);
    exp_at(21, "tmo_last_capture", SelState, 3);
    exp_at(21, "tmo_last_start", SelDpStart, 1);
    exp_at(22, "tmo_display", SelState, 4);
    exp_at(22, "tmo_flag", SelTimedOut, 1);
    exp_at(22, "tmo_start_off", SelDpStart, 0);
    tick();
    bus.arm = 1'b0;
    tick_n(21);

    // Re-arm clears timed_out; abort with full in CAPTURE goes to IDLE.
    bus.arm = 1'b1;
    exp_at(1, "clr_clears_tmo", SelTimedOut, 0);
    exp_at(6, "abort_pre", SelState, 3);
    tick();
    bus.arm = 1'b0;
    tick_n(6);
    bus.abort   = 1'b1;
    bus.dp_full = 4'hF;
    exp_at(1, "abort_state", SelState, 0);
    exp_at(1, "abort_start", SelDpStart, 0);
    exp_at(1, "abort_busy", SelBusy, 0);
    tick();
    bus.abort   = 1'b0;
    bus.dp_full = 4'h0;

    // Zoom saturates at 9; inc+dec together holds.
    for (int i = 0; i < 12; i++) begin
      bus.zoom_inc = 1'b1;
      exp_at(1, "zoom_inc", SelZoom, (i + 1 > 9) ? 9 : i + 1);
      tick();
    end
    bus.zoom_dec = 1'b1;
    exp_at(1, "zoom_both", SelZoom, 9);
    tick();
    bus.zoom_inc = 1'b0;
    exp_at(1, "zoom_dec", SelZoom, 8);
    tick();
    bus.zoom_dec = 1'b0;

    // Offset floors at 0, counts up, inc+dec together holds.
    bus.off_dec = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_at(1, "off_dec_floor", SelOffset, 0);
      tick();
    end
    bus.off_dec = 1'b0;
    bus.off_inc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_at(1, "off_inc", SelOffset, i + 1);
      tick();
    end
    bus.off_dec = 1'b1;
    exp_at(1, "off_both", SelOffset, 3);
    tick();
    bus.off_inc = 1'b0;
    bus.off_dec = 1'b0;

    // Async reset mid-CAPTURE: outputs clear without a clock edge.
    bus.arm = 1'b1;
    exp_at(6, "rst_pre_capture", SelState, 3);
    exp_at(6, "zoom_persists", SelZoom, 8);
    tick();
    bus.arm = 1'b0;
    tick_n(6);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", int'(bus.state), 0);
    check("arst_dp_start", int'(bus.dp_start), 0);
    check("arst_dp_reset", int'(bus.dp_reset), 0);
    check("arst_busy", int'(bus.busy), 0);
    check("arst_timed_out", int'(bus.timed_out), 0);
    check("arst_zoom", int'(bus.zoom), 0);
    check("arst_offset", int'(bus.offset), 0);
    #5;
    reset = 1'b1;
    tick_n(2);
    exp_at(0, "post_rst_idle", SelState, 0);
    tick_n(2);

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
